// File: rtl/memory_responder_pkg.sv
// Shared types for the memory responder: request encodings, responder FSM states
// and the byte-lane helpers used to place sub-word accesses in a 32-bit word.
package torrence_types;

    typedef enum logic [0:0] {LOAD, STORE} memory_operation_e;
    typedef enum logic [1:0] {BYTE, HALF, WORD} memory_access_size_e;
    typedef enum logic [1:0] {IDLE, BUSY, RESPOND, DRAIN} memory_responder_state_e;

    // Lowest byte lane touched by an access; alignment bits below the size are dropped.
    function automatic logic [1:0] lane_offset(memory_access_size_e size, logic [1:0] addr);
        case (size)
            BYTE:    return addr;
            HALF:    return {addr[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(memory_access_size_e size, logic [1:0] addr);
        logic [1:0] off;
        off = lane_offset(size, addr);
        case (size)
            BYTE:    return 4'b0001 << off;
            HALF:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Reset distribution interface and the memory_if request/response bundle
// shared between a requester (master) and the responding memory (slave).
interface reset_if;
    logic reset;

    modport master (output reset);
    modport slave  (input reset);
endinterface

interface memory_if #(parameter int XLEN = 32);
    import torrence_types::*;

    logic                req_valid;
    memory_operation_e   req_operation;
    memory_access_size_e req_size;
    logic [XLEN-1:0]     req_address;
    logic [XLEN-1:0]     req_store_word;
    logic [XLEN-1:0]     req_loaded_word;
    logic                req_fulfilled;

    modport master (
        output req_valid, req_operation, req_size, req_address, req_store_word,
        input  req_loaded_word, req_fulfilled
    );
    modport slave (
        input  req_valid, req_operation, req_size, req_address, req_store_word,
        output req_loaded_word, req_fulfilled
    );
endinterface

// File: rtl/memory_responder_array.sv
// Word-organised backing store: byte-enabled synchronous write, combinational read.
// The word index wraps modulo the array size so upper address bits alias.
module memory_responder_array #(
    parameter int MEM_SIZE = 4096,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            write_en,
    input  logic [3:0]      byte_en,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] write_word,
    output logic [XLEN-1:0] read_word
);

    localparam int WORDS = MEM_SIZE / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [XLEN-1:0] mem [WORDS];
    logic [IW-1:0]   index;

    assign index = IW'(address >> 2) & IW'(WORDS - 1);

    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[index][8*i +: 8] <= write_word[8*i +: 8];
            end
        end
    end

    assign read_word = mem[index];

endmodule

// File: rtl/memory_responder.sv
// memory_if responder: accepts one request at a time, waits the programmed latency,
// answers with a single-cycle fulfilled pulse, then waits for the requester to drop valid.
module memory_responder
    import torrence_types::*;
#(
    parameter int MEM_SIZE      = 4096,
    parameter int XLEN          = 32,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic     clk,
    reset_if.slave   rst_if,
    memory_if.slave  req_if
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    memory_responder_state_e state, next_state;
    logic [CW-1:0]           count;

    memory_operation_e   op_q;
    memory_access_size_e size_q;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     store_q;

    logic [XLEN-1:0] held_word;
    logic [XLEN-1:0] read_word;
    logic [XLEN-1:0] write_word;
    logic [XLEN-1:0] resp_word;
    logic [XLEN-1:0] loaded_word;
    logic [3:0]      byte_en;
    logic [1:0]      offset;
    logic            rst;
    logic            accept;
    logic            respond;
    logic            write_en;

    assign rst    = rst_if.reset;
    assign accept = (state == IDLE) && req_if.req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            held_word <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                count <= (req_if.req_operation == LOAD) ? CW'(READ_LATENCY - 1)
                                                        : CW'(WRITE_LATENCY - 1);
            end else if (state == BUSY && count != '0) begin
                count <= count - 1'b1;
            end
            if (state == RESPOND) held_word <= resp_word;
        end
    end

    // Request fields are captured once at accept; later changes on the bus are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= req_if.req_operation;
            size_q  <= req_if.req_size;
            addr_q  <= req_if.req_address;
            store_q <= req_if.req_store_word;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_if.req_valid) next_state = BUSY;
            BUSY:    if (count == '0) next_state = RESPOND;
            RESPOND: next_state = DRAIN;
            DRAIN:   if (!req_if.req_valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A reset arriving during RESPOND suppresses both the pulse and the array write.
    always_comb begin
        offset     = lane_offset(size_q, addr_q[1:0]);
        byte_en    = byte_enable(size_q, addr_q[1:0]);
        write_word = store_q << (8 * offset);
        resp_word  = '0;
        if (op_q == LOAD) begin
            resp_word = read_word >> (8 * offset);
            case (size_q)
                BYTE:    resp_word = resp_word & XLEN'(32'h0000_00FF);
                HALF:    resp_word = resp_word & XLEN'(32'h0000_FFFF);
                default: resp_word = resp_word;
            endcase
        end
        respond     = (state == RESPOND) && !rst;
        write_en    = respond && (op_q == STORE);
        loaded_word = respond ? resp_word : held_word;
    end

    assign req_if.req_fulfilled   = respond;
    assign req_if.req_loaded_word = loaded_word;

    memory_responder_array #(
        .MEM_SIZE (MEM_SIZE),
        .XLEN     (XLEN)
    ) u_array (
        .clk        (clk),
        .write_en   (write_en),
        .byte_en    (byte_en),
        .address    (addr_q),
        .write_word (write_word),
        .read_word  (read_word)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed vector table, multi-cycle corner sequences,
// then random traffic checked against a byte-array model of main memory.
module tb_memory_responder;
    import torrence_types::*;

    localparam int MEM_SIZE = 4096;
    localparam int LAT      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    reset_if             rst_if ();
    memory_if #(.XLEN(32)) req_if ();

    memory_responder #(
        .MEM_SIZE      (MEM_SIZE),
        .XLEN          (32),
        .READ_LATENCY  (LAT),
        .WRITE_LATENCY (LAT)
    ) dut (
        .clk    (clk),
        .rst_if (rst_if),
        .req_if (req_if)
    );

    typedef struct {
        memory_operation_e   op;
        memory_access_size_e sz;
        logic [31:0]         addr;
        logic [31:0]         data;
        logic [31:0]         exp;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] model [MEM_SIZE];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference memory: plain byte array, little-endian, aligned down to the access size.
    function automatic logic [31:0] model_access(memory_operation_e op, memory_access_size_e sz,
                                                 logic [31:0] addr, logic [31:0] data);
        int n;
        int base;
        logic [31:0] r;
        n    = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
        base = (int'(addr % MEM_SIZE) / n) * n;
        r    = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (op == STORE) model[base + i] = data[8*i +: 8];
            else             r[8*i +: 8] = model[base + i];
        end
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns the load word and cycles from accept to pulse.
    task automatic do_req(memory_operation_e op, memory_access_size_e sz, logic [31:0] addr,
                          logic [31:0] data, output logic [31:0] loaded, output int n);
        req_if.req_operation  = op;
        req_if.req_size       = sz;
        req_if.req_address    = addr;
        req_if.req_store_word = data;
        req_if.req_valid      = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!req_if.req_fulfilled && n < 50);
        loaded = req_if.req_loaded_word;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!req_if.req_fulfilled && n < 50);
    endtask

    vec_t        tbl [$];
    logic [31:0] ld;
    logic [31:0] exp_ld;
    int          n;
    int          pulses;
    int          first;

    initial begin
        rst_if.reset          = 1'b1;
        req_if.req_valid      = 1'b0;
        req_if.req_operation  = LOAD;
        req_if.req_size       = WORD;
        req_if.req_address    = 32'h0;
        req_if.req_store_word = 32'h0;

        repeat (3) begin
            @(posedge clk); #1;
            check("reset_fulfilled", {31'h0, req_if.req_fulfilled}, 32'h0);
            check("reset_loaded", req_if.req_loaded_word, 32'h0);
            check("reset_state", 32'(dut.state), 32'(IDLE));
        end
        @(negedge clk);
        rst_if.reset = 1'b0;

        tbl.push_back('{STORE, WORD, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000});
        tbl.push_back('{LOAD,  WORD, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF});
        tbl.push_back('{STORE, BYTE, 32'h0000_0041, 32'hAAAA_AA12, 32'h0000_0000});
        tbl.push_back('{STORE, HALF, 32'h0000_0042, 32'h5555_ABCD, 32'h0000_0000});
        tbl.push_back('{LOAD,  WORD, 32'h0000_0040, 32'h0,         32'hABCD_12EF});
        tbl.push_back('{LOAD,  BYTE, 32'h0000_0041, 32'h0,         32'h0000_0012});
        tbl.push_back('{LOAD,  HALF, 32'h0000_0043, 32'h0,         32'h0000_ABCD});
        tbl.push_back('{STORE, WORD, 32'h0000_1000, 32'h5A5A_5A5A, 32'h0000_0000});
        tbl.push_back('{LOAD,  WORD, 32'h0000_0000, 32'h0,         32'h5A5A_5A5A});
        tbl.push_back('{STORE, WORD, 32'h0000_0080, 32'h2222_2222, 32'h0000_0000});
        tbl.push_back('{STORE, WORD, 32'h0000_0084, 32'h4444_4444, 32'h0000_0000});
        tbl.push_back('{LOAD,  WORD, 32'h0000_0087, 32'h0,         32'h4444_4444});

        for (int i = 0; i < tbl.size(); i++) begin
            do_req(tbl[i].op, tbl[i].sz, tbl[i].addr, tbl[i].data, ld, n);
            check($sformatf("vec%0d_latency", i), 32'(n), 32'(LAT + 1));
            check($sformatf("vec%0d_loaded", i), ld, tbl[i].exp);
        end
        check("held_loaded_idle", req_if.req_loaded_word, 32'h4444_4444);

        // Sticky valid: one pulse only, then a fresh request after a single low cycle.
        req_if.req_operation = LOAD;
        req_if.req_size      = WORD;
        req_if.req_address   = 32'h0000_0040;
        req_if.req_valid     = 1'b1;
        pulses = 0;
        first  = 0;
        ld     = 32'h0;
        for (int c = 1; c <= LAT + 1 + 20; c++) begin
            @(posedge clk); #1;
            if (req_if.req_fulfilled) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    ld    = req_if.req_loaded_word;
                end
            end
        end
        check("sticky_pulses", 32'(pulses), 32'd1);
        check("sticky_latency", 32'(first), 32'(LAT + 1));
        check("sticky_loaded", ld, 32'hABCD_12EF);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        @(negedge clk);
        do_req(LOAD, WORD, 32'h0000_0084, 32'h0, ld, n);
        check("after_sticky_latency", 32'(n), 32'(LAT + 1));
        check("after_sticky_loaded", ld, 32'h4444_4444);

        // Reset two cycles into a write, with a load already presented during reset.
        req_if.req_operation  = STORE;
        req_if.req_size       = WORD;
        req_if.req_address    = 32'h0000_0080;
        req_if.req_store_word = 32'h1111_1111;
        req_if.req_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_if.reset         = 1'b1;
        req_if.req_operation = LOAD;
        repeat (2) begin
            @(posedge clk); #1;
            check("midwrite_reset_nopulse", {31'h0, req_if.req_fulfilled}, 32'h0);
        end
        @(negedge clk);
        rst_if.reset = 1'b0;
        wait_pulse(n);
        check("reset_valid_latency", 32'(n), 32'(LAT + 1));
        check("midwrite_old_value", req_if.req_loaded_word, 32'h2222_2222);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset arriving during the response cycle of a store.
        req_if.req_operation  = STORE;
        req_if.req_size       = WORD;
        req_if.req_address    = 32'h0000_0084;
        req_if.req_store_word = 32'h3333_3333;
        req_if.req_valid      = 1'b1;
        repeat (LAT + 1) @(posedge clk);
        #1;
        rst_if.reset     = 1'b1;
        req_if.req_valid = 1'b0;
        @(negedge clk);
        check("respond_reset_nopulse", {31'h0, req_if.req_fulfilled}, 32'h0);
        @(negedge clk);
        rst_if.reset = 1'b0;
        @(negedge clk);
        do_req(LOAD, WORD, 32'h0000_0084, 32'h0, ld, n);
        check("respond_reset_old_value", ld, 32'h4444_4444);

        // Random traffic over an initialised window, with aliased upper address bits.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            void'(model_access(STORE, WORD, 32'h100 + 32'(4 * w), d));
            do_req(STORE, WORD, 32'h100 + 32'(4 * w), d, ld, n);
        end
        for (int i = 0; i < 60; i++) begin
            memory_operation_e   op;
            memory_access_size_e sz;
            logic [31:0]         addr;
            logic [31:0]         data;
            op   = ($urandom_range(0, 1) == 0) ? LOAD : STORE;
            sz   = memory_access_size_e'($urandom_range(0, 2));
            addr = 32'h100 + 32'($urandom_range(0, 63)) + 32'(MEM_SIZE * $urandom_range(0, 3));
            data = $urandom;
            exp_ld = model_access(op, sz, addr, data);
            do_req(op, sz, addr, data, ld, n);
            check($sformatf("rand%0d_latency", i), 32'(n), 32'(LAT + 1));
            check($sformatf("rand%0d_loaded", i), ld, exp_ld);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
